i2c_slave_regfile: RTL and testbench
====================================

// Module: i2c_slave_regfile
// PURPOSE
//  Parametrised register-file driver behind the I2C slave byte core; successor to the fixed-command slave driver.
//  A write transaction sets a register pointer, then writes sequential registers; a read transaction streams registers.
//  Pointer auto-increments with wrap; RO chip-ID and status registers plus NUM_REGS-2 RW registers exported to fabric.
//  Sits between the slave byte core (received/sended toggles, data bytes) and application logic.
// PARAMETERS
//  SLAVE_ADDRESS  7'h3C  7-bit bus address driven on address
//  NUM_REGS       8      register count, 3..128; index 0 = CHIP_ID (RO), 1 = status_in (RO), 2..NUM_REGS-1 RW
//  PTR_W          3      pointer width, must equal clog2(NUM_REGS)
//  CHIP_ID        8'hA5  value returned at index 0
//  RW_RESET       8'h00  reset value of every RW register
// PORTS
//  clk          in   1            clock, all logic on posedge
//  reset        in   1            synchronous, active-low
//  address      out  7            constant SLAVE_ADDRESS
//  datareceive  in   8            byte from slave core, valid when received rises
//  received     in   1            level; rising edge = one byte received from master
//  datasend     out  8            byte offered to slave core for next master read
//  sended       in   1            level; rising edge = datasend byte consumed by master
//  bus_stop     in   1            one-cycle pulse on I2C STOP / repeated START
//  status_in    in   8            live status sampled when index 1 is loaded into datasend
//  regs_flat    out  NUM_REGS*8   all registers, index i at [8*i+7:8*i]; RO slots reflect CHIP_ID/status_in
//  wr_strobe    out  1            one-cycle pulse when a RW register is written
//  wr_index     out  PTR_W        index written, valid with wr_strobe
//  err          out  1            sticky: bad pointer or received/sended collision; cleared by reset only
// BEHAVIOUR
//  Reset (reset==0 at posedge): ptr=0, state=IDLE, datasend=8'h00, RW regs=RW_RESET, wr_strobe=0, err=0, edge history=0.
//  Edge detect: rx_ev = received & ~received_d; tx_ev = sended & ~sended_d; history registered every cycle.
//  FSM states and transitions (evaluated on the cycle rx_ev/tx_ev is seen):
//   IDLE : rx_ev, datareceive<NUM_REGS -> ptr=datareceive[PTR_W-1:0], DATA
//          rx_ev, datareceive>=NUM_REGS -> err=1, LOCK, ptr unchanged
//          tx_ev -> ptr=ptr+1 (read without pointer set continues from current ptr), stay IDLE
//   DATA : rx_ev -> write datareceive to reg[ptr] if ptr>=2 (wr_strobe=1, wr_index=ptr), else discard; ptr=ptr+1
//          tx_ev -> ptr=ptr+1
//   LOCK : all rx_ev/tx_ev ignored, ptr frozen
//   any  : bus_stop -> IDLE (ptr kept); bus_stop has priority over rx_ev/tx_ev in the same cycle
//  Pointer wrap: ptr==NUM_REGS-1 increments to 0 (not to 2^PTR_W when NUM_REGS not a power of 2).
//  Collision: rx_ev and tx_ev same cycle -> rx_ev processed, tx_ev dropped, err=1.
//  datasend: registered every cycle from reg[ptr] (index 1 -> status_in); latency 1 cycle after ptr changes.
//   Slave core must not sample datasend earlier than 2 clk after tx_ev.
//  wr_strobe: high exactly one cycle, the cycle after rx_ev; RW register value visible on regs_flat same cycle.
//  Reset mid-transaction: all state cleared immediately; a received/sended level already high at reset release
//   does not generate an event (history reset to 0 would, so history is loaded with current level on first cycle out of reset).
// TESTING
//  T1 reset, rx 8'h00 then bus_stop, then tx_ev -> datasend=8'hA5 within 2 clk, next datasend=status_in.
//  T2 rx 8'h02,8'h11,8'h22 -> wr_strobe twice, wr_index 2 then 3, regs_flat[23:16]=8'h11, [31:24]=8'h22.
//  T3 rx 8'h07,8'hEE,8'h55 (NUM_REGS=8) -> reg7=8'hEE, ptr wraps to 0, 8'h55 discarded at index 0, ptr=1.
//  T4 rx 8'h09 -> err=1, further rx 8'h33 writes nothing; bus_stop then rx 8'h02,8'h44 -> reg2=8'h44, err stays 1.
//  T5 rx_ev and tx_ev same cycle in DATA at ptr=4 -> reg4 written, ptr=5 (not 6), err=1.
//  T6 assert reset mid-write with received held high -> no spurious write after release, all RW regs=RW_RESET.

Source files
------------

// File: rtl/i2c_slave_regfile_if.sv
// Byte-level link between the I2C slave byte core and the register-file driver.
// The byte core drives through the master modport; the register file uses the slave modport.
interface i2c_slave_regfile_if;
    logic [6:0] address;
    logic [7:0] datareceive;
    logic       received;
    logic [7:0] datasend;
    logic       sended;
    logic       bus_stop;

    modport master (
        input  address,
        input  datasend,
        output datareceive,
        output received,
        output sended,
        output bus_stop
    );

    modport slave (
        output address,
        output datasend,
        input  datareceive,
        input  received,
        input  sended,
        input  bus_stop
    );
endinterface

// File: rtl/i2c_slave_regfile.sv
// Register-file driver behind the I2C slave byte core: pointer-set write, sequential
// write/read with wrap, read-only chip-ID and live status, RW registers exported to fabric.
module i2c_slave_regfile #(
    parameter logic [6:0] SLAVE_ADDRESS = 7'h3C,
    parameter int         NUM_REGS      = 8,
    parameter int         PTR_W         = 3,
    parameter logic [7:0] CHIP_ID       = 8'hA5,
    parameter logic [7:0] RW_RESET      = 8'h00
) (
    input  logic                  clk,
    input  logic                  reset,
    i2c_slave_regfile_if.slave    bus,
    input  logic [7:0]            status_in,
    output logic [NUM_REGS*8-1:0] regs_flat,
    output logic                  wr_strobe,
    output logic [PTR_W-1:0]      wr_index,
    output logic                  err
);

    typedef enum logic [1:0] {IDLE, DATA, LOCK} state_t;

    localparam logic [PTR_W-1:0] LAST   = PTR_W'(NUM_REGS - 1);
    localparam logic [8:0]       NREGS9 = 9'(NUM_REGS);

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    state_t           state, state_nxt;
    logic [PTR_W-1:0] ptr, ptr_nxt;
    logic             wr_en, err_set;
    logic             received_p1, sended_p1, armed_p1;
    logic             rx_ev, tx_ev;
    logic [7:0]       rw_regs [NUM_REGS];
    logic [7:0]       rd_byte;
    logic [7:0]       datasend_p1;

    assign bus.address  = SLAVE_ADDRESS;
    assign bus.datasend = datasend_p1;

    // Stage p1: edge history; armed_p1 masks the first cycle out of reset so a
    // level already high at release is absorbed instead of seen as an edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            received_p1 <= 1'b0;
            sended_p1   <= 1'b0;
            armed_p1    <= 1'b0;
        end else begin
            received_p1 <= bus.received;
            sended_p1   <= bus.sended;
            armed_p1    <= 1'b1;
        end
    end

    assign rx_ev = bus.received & ~received_p1 & armed_p1;
    assign tx_ev = bus.sended   & ~sended_p1   & armed_p1;

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        wr_en     = 1'b0;
        err_set   = 1'b0;
        if (bus.bus_stop) begin
            state_nxt = IDLE;
        end else begin
            err_set = rx_ev & tx_ev;
            case (state)
                IDLE: begin
                    if (rx_ev) begin
                        if ({1'b0, bus.datareceive} < NREGS9) begin
                            ptr_nxt   = bus.datareceive[PTR_W-1:0];
                            state_nxt = DATA;
                        end else begin
                            err_set   = 1'b1;
                            state_nxt = LOCK;
                        end
                    end else if (tx_ev) begin
                        ptr_nxt = ptr_inc(ptr);
                    end
                end
                DATA: begin
                    if (rx_ev) begin
                        wr_en   = (ptr >= PTR_W'(2));
                        ptr_nxt = ptr_inc(ptr);
                    end else if (tx_ev) begin
                        ptr_nxt = ptr_inc(ptr);
                    end
                end
                default: ;
            endcase
        end
    end

    // Stage p1: control state
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            ptr       <= '0;
            err       <= 1'b0;
            wr_strobe <= 1'b0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            err       <= err | err_set;
            wr_strobe <= wr_en;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) wr_index <= ptr;
    end

    always_comb begin
        rd_byte = rw_regs[ptr];
        if (ptr == '0)
            rd_byte = CHIP_ID;
        else if (ptr == PTR_W'(1))
            rd_byte = status_in;
    end

    // Stage p1: register storage and the byte offered for the next master read
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) rw_regs[i] <= RW_RESET;
            datasend_p1 <= 8'h00;
        end else begin
            if (wr_en) rw_regs[ptr] <= bus.datareceive;
            datasend_p1 <= rd_byte;
        end
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_flat
        if (i == 0) begin : g_id
            assign regs_flat[7:0] = CHIP_ID;
        end else if (i == 1) begin : g_st
            assign regs_flat[15:8] = status_in;
        end else begin : g_rw
            assign regs_flat[8*i +: 8] = rw_regs[i];
        end
    end

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Scoreboard bench for i2c_slave_regfile: expected writes and read bytes are queued
// by the stimulus and checked by an independent monitor on the falling edge.
module tb_i2c_slave_regfile;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  status_in = 8'h5A;
    logic [63:0] regs_flat;
    logic        wr_strobe;
    logic [2:0]  wr_index;
    logic        err;

    always #5 clk = ~clk;

    i2c_slave_regfile_if bus();

    i2c_slave_regfile #(
        .SLAVE_ADDRESS(7'h3C),
        .NUM_REGS(8),
        .PTR_W(3),
        .CHIP_ID(8'hA5),
        .RW_RESET(8'h00)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .status_in(status_in),
        .regs_flat(regs_flat),
        .wr_strobe(wr_strobe),
        .wr_index(wr_index),
        .err(err)
    );

    typedef struct {
        int         idx;
        logic [7:0] val;
    } wr_t;

    wr_t        wr_q[$];
    logic [7:0] rd_q[$];
    logic       rd_smp = 1'b0;
    int         n_tests = 0;
    int         n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops expectations whenever the DUT strobes a write or the core samples datasend
    always @(negedge clk) begin
        if (wr_strobe === 1'b1) begin
            if (wr_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL wr_unexpected: index %0d value %0h, no write expected",
                         wr_index, regs_flat[8*wr_index +: 8]);
            end else begin
                wr_t e;
                e = wr_q.pop_front();
                check("wr_index", 64'(wr_index), 64'(e.idx));
                check("wr_data", 64'(regs_flat[8*e.idx +: 8]), 64'(e.val));
            end
        end
        if (rd_smp) begin
            if (rd_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL rd_underflow: datasend %0h sampled with no expectation", bus.datasend);
            end else begin
                logic [7:0] r;
                r = rd_q.pop_front();
                check("datasend", 64'(bus.datasend), 64'(r));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rx_byte(input logic [7:0] b);
        bus.datareceive = b;
        bus.received    = 1'b1;
        tick(1);
        bus.received    = 1'b0;
        tick(1);
    endtask

    task automatic tx_read(input logic [7:0] exp);
        rd_q.push_back(exp);
        rd_smp     = 1'b1;
        bus.sended = 1'b1;
        tick(1);
        rd_smp     = 1'b0;
        bus.sended = 1'b0;
        tick(1);
    endtask

    task automatic stop();
        bus.bus_stop = 1'b1;
        tick(1);
        bus.bus_stop = 1'b0;
        tick(1);
    endtask

    task automatic exp_wr(input int idx, input logic [7:0] val);
        wr_t e;
        e.idx = idx;
        e.val = val;
        wr_q.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.datareceive = 8'h00;
        bus.received    = 1'b0;
        bus.sended      = 1'b0;
        bus.bus_stop    = 1'b0;
        tick(3);
        check("rst_datasend", 64'(bus.datasend), 64'h00);
        check("rst_wr_strobe", 64'(wr_strobe), 64'h0);
        check("rst_err", 64'(err), 64'h0);
        check("rst_regs_flat", regs_flat, {48'h0, 8'h5A, 8'hA5});
        check("address", 64'(bus.address), 64'h3C);
        reset = 1'b1;
        tick(2);

        // T1: pointer to chip-ID, then stream across into live status
        rx_byte(8'h00);
        stop();
        tx_read(8'hA5);
        tx_read(8'h5A);

        // T2: sequential writes to 2 and 3, read back
        rx_byte(8'h02);
        exp_wr(2, 8'h11);
        rx_byte(8'h11);
        exp_wr(3, 8'h22);
        rx_byte(8'h22);
        check("t2_reg2", 64'(regs_flat[23:16]), 64'h11);
        check("t2_reg3", 64'(regs_flat[31:24]), 64'h22);
        stop();
        rx_byte(8'h02);
        tx_read(8'h11);
        tx_read(8'h22);

        // T3: write at last index wraps; byte landing on index 0 is discarded
        stop();
        rx_byte(8'h07);
        exp_wr(7, 8'hEE);
        rx_byte(8'hEE);
        rx_byte(8'h55);
        tx_read(8'h5A);
        tx_read(8'h11);
        check("t3_reg7", 64'(regs_flat[63:56]), 64'hEE);
        check("t3_chip_id", 64'(regs_flat[7:0]), 64'hA5);

        // T4: bad pointer locks until bus_stop, error stays sticky
        stop();
        rx_byte(8'h09);
        check("t4_err_set", 64'(err), 64'h1);
        rx_byte(8'h33);
        tx_read(8'h22);
        tx_read(8'h22);
        stop();
        rx_byte(8'h02);
        exp_wr(2, 8'h44);
        rx_byte(8'h44);
        check("t4_reg2", 64'(regs_flat[23:16]), 64'h44);
        check("t4_reg3_untouched", 64'(regs_flat[31:24]), 64'h22);
        check("t4_err_sticky", 64'(err), 64'h1);

        // T6: reset asserted mid-write with received held high across release
        bus.datareceive = 8'h99;
        bus.received    = 1'b1;
        reset           = 1'b0;
        tick(2);
        reset = 1'b1;
        tick(3);
        bus.received = 1'b0;
        tick(2);
        check("t6_err_cleared", 64'(err), 64'h0);
        check("t6_rw_regs", 64'(regs_flat[63:16]), 64'h0);
        check("t6_datasend", 64'(bus.datasend), 64'hA5);

        // T5: rx/tx collision in DATA at index 4
        rx_byte(8'h04);
        check("t5_err_before", 64'(err), 64'h0);
        bus.datareceive = 8'h77;
        bus.received    = 1'b1;
        bus.sended      = 1'b1;
        exp_wr(4, 8'h77);
        tick(1);
        bus.received = 1'b0;
        bus.sended   = 1'b0;
        tick(1);
        check("t5_err_collision", 64'(err), 64'h1);
        check("t5_reg4", 64'(regs_flat[39:32]), 64'h77);
        tx_read(8'h00);
        tx_read(8'h00);
        tx_read(8'h00);
        tx_read(8'hA5);

        tick(2);
        check("wr_queue_drained", 64'(wr_q.size()), 64'h0);
        check("rd_queue_drained", 64'(rd_q.size()), 64'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
